// File: rtl/uart_tx_fifo_feeder.sv
// uart_tx_fifo_feeder
// Byte FIFO plus launch controller placed directly upstream of a UART
// transmitter. Producers push bytes at any rate; the feeder pops one byte,
// strobes the transmitter's data-valid for one clock, then waits for the
// transmitter's done pulse before launching the next byte.
//
// Ports:
//   i_Clock      system clock
//   i_Reset      synchronous, active-low reset
//   i_Wr_En      push i_Wr_Byte this cycle
//   i_Wr_Byte    byte to enqueue
//   i_Ovf_Clr    clears o_Overflow (a same-edge drop wins)
//   o_Full       FIFO holds DEPTH bytes
//   o_Empty      FIFO holds 0 bytes
//   o_Count      bytes buffered, excluding the byte in flight
//   o_Overflow   sticky: a push was dropped
//   o_Busy       FIFO non-empty or a byte in flight
//   o_TX_DV      one-cycle launch strobe to the transmitter
//   o_TX_Byte    byte to transmit, held until the transmitter's done pulse
//   i_TX_Active  transmitter busy flag
//   i_TX_Done    transmitter one-cycle end-of-frame pulse
module uart_tx_fifo_feeder #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Wr_En,
    input  logic [7:0]        i_Wr_Byte,
    input  logic              i_Ovf_Clr,
    output logic              o_Full,
    output logic              o_Empty,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Overflow,
    output logic              o_Busy,
    output logic              o_TX_DV,
    output logic [7:0]        o_TX_Byte,
    input  logic              i_TX_Active,
    input  logic              i_TX_Done
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_DONE = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_n;
    logic [7:0]          mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]    count_n;
    logic                pop_c;
    logic                push_c;
    logic                drop_c;
    logic                full_c;

    // Next-state: launch only when data is buffered and the transmitter is idle
    always_comb begin
        state_n = state_q;
        pop_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if ((o_Count != '0) && !i_TX_Active) begin
                    pop_c   = 1'b1;
                    state_n = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (i_TX_Done) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Push acceptance: a full FIFO still takes a push when a pop frees a slot
    always_comb begin
        full_c = (o_Count == FULL_CNT);
        push_c = i_Wr_En && (!full_c || pop_c);
        drop_c = i_Wr_En && full_c && !pop_c;
    end

    // Occupancy after this edge
    always_comb begin
        count_n = o_Count;
        case ({push_c, pop_c})
            2'b10:   count_n = o_Count + CNT_W'(1);
            2'b01:   count_n = o_Count - CNT_W'(1);
            default: count_n = o_Count;
        endcase
    end

    // Storage array is intentionally left unreset
    always_ff @(posedge i_Clock) begin
        if (i_Reset && push_c) begin
            mem[wr_ptr] <= i_Wr_Byte;
        end
    end

    // State, pointers, flags and transmitter interface
    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            state_q    <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_Count    <= '0;
            o_Full     <= 1'b0;
            o_Empty    <= 1'b1;
            o_Busy     <= 1'b0;
            o_Overflow <= 1'b0;
            o_TX_DV    <= 1'b0;
            o_TX_Byte  <= 8'h00;
        end else begin
            state_q <= state_n;
            o_Count <= count_n;
            o_Full  <= (count_n == FULL_CNT);
            o_Empty <= (count_n == '0);
            o_Busy  <= (count_n != '0) || (state_n == WAIT_DONE);
            o_TX_DV <= pop_c;

            // Pointers wrap naturally because DEPTH is a power of two
            if (push_c) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop_c) begin
                rd_ptr    <= rd_ptr + ADDR_W'(1);
                o_TX_Byte <= mem[rd_ptr];
            end

            // A drop on the same edge as a clear leaves the flag set
            if (drop_c) begin
                o_Overflow <= 1'b1;
            end else if (i_Ovf_Clr) begin
                o_Overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Testbench for uart_tx_fifo_feeder: a behavioural transmitter model consumes
// DV strobes and compares each launched byte against a scoreboard queue that
// is filled as bytes are pushed.
module tb_uart_tx_fifo_feeder;

    localparam int unsigned CW    = 5;
    localparam int          FRAME = 10 * 4;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          wr_en    = 1'b0;
    logic [7:0]    wr_byte  = 8'h00;
    logic          ovf_clr  = 1'b0;
    logic          tx_active = 1'b0;
    logic          tx_done  = 1'b0;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          ovf;
    logic          busy;
    logic          tx_dv;
    logic [7:0]    tx_byte;

    logic [7:0] sb[$];
    int  n_total = 0;
    int  n_bad   = 0;
    int  cyc     = 0;
    int  push_cyc = 0;
    int  dv_cyc  = -1;
    int  done_cyc = -1;
    int  dv_total = 0;
    int  peak    = 0;
    int  tx_cnt  = 0;
    int  mark;
    int  rel_cyc;
    bit  tx_run   = 1'b0;
    bit  tx_hold  = 1'b0;
    bit  tx_force = 1'b0;
    bit  gap_chk  = 1'b0;

    uart_tx_fifo_feeder #(.DEPTH(16)) dut (
        .i_Clock    (clk),
        .i_Reset    (rst_n),
        .i_Wr_En    (wr_en),
        .i_Wr_Byte  (wr_byte),
        .i_Ovf_Clr  (ovf_clr),
        .o_Full     (full),
        .o_Empty    (empty),
        .o_Count    (count),
        .o_Overflow (ovf),
        .o_Busy     (busy),
        .o_TX_DV    (tx_dv),
        .o_TX_Byte  (tx_byte),
        .i_TX_Active(tx_active),
        .i_TX_Done  (tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Transmitter model: a frame lasts FRAME clocks; done and active drop together
    initial begin
        logic [7:0] exp_b;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            tx_done = 1'b0;
            if (32'(count) > peak) peak = 32'(count);
            if (tx_dv) begin
                chk("dv_tx_idle", 32'(tx_run), 0);
                if (gap_chk && done_cyc >= 0) chk("dv_gap", cyc - done_cyc, 2);
                if (sb.size() == 0) begin
                    chk("dv_unexpected", 1, 0);
                end else begin
                    exp_b = sb.pop_front();
                    chk("tx_byte", 32'(tx_byte), 32'(exp_b));
                end
                dv_cyc = cyc;
                dv_total++;
                tx_run = 1'b1;
                tx_cnt = 0;
            end else if (tx_run) begin
                if (!tx_hold) tx_cnt++;
                if (tx_cnt >= FRAME) begin
                    tx_run   = 1'b0;
                    tx_done  = 1'b1;
                    done_cyc = cyc;
                end
            end
            tx_active = tx_run | tx_force;
        end
    end

    // Present a push for the next edge; acc says whether it should be accepted
    task automatic push(input logic [7:0] b, input bit acc);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_byte = b;
        push_cyc = cyc + 1;
        if (acc) sb.push_back(b);
    endtask

    task automatic wr_off();
        @(negedge clk);
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_done) return;
        end
        chk("done_timeout", 0, 1);
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy && !tx_run) return;
        end
        chk("drain_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_dv", 32'(tx_dv), 0);
        chk("rst_byte", 32'(tx_byte), 0);
        rst_n = 1'b1;

        // Single byte: latency, busy fall and empty
        mark = dv_total;
        push(8'hA5, 1'b1);
        wr_off();
        wait_done();
        chk("t1_busy_at_done", 32'(busy), 1);
        @(negedge clk);
        chk("t1_busy_after", 32'(busy), 0);
        chk("t1_empty", 32'(empty), 1);
        chk("t1_latency", dv_cyc - push_cyc, 1);
        chk("t1_dv_count", dv_total - mark, 1);

        // Five back-to-back bytes with done-to-DV gap and peak occupancy
        mark = dv_total;
        peak = 0;
        done_cyc = -1;
        gap_chk = 1'b1;
        for (int i = 1; i <= 5; i++) push(8'(i), 1'b1);
        wr_off();
        drain(400);
        gap_chk = 1'b0;
        chk("t2_dv_count", dv_total - mark, 5);
        chk("t2_peak", peak, 4);

        // Fill against a stalled transmitter, overflow and full+pop push
        tx_hold = 1'b1;
        for (int i = 0; i < 17; i++) push(8'h10 + 8'(i), 1'b1);
        wr_off();
        @(negedge clk);
        chk("t3_count", 32'(count), 16);
        chk("t3_full", 32'(full), 1);
        chk("t3_ovf_before", 32'(ovf), 0);
        chk("t3_busy", 32'(busy), 1);
        push(8'hFF, 1'b0);
        wr_off();
        chk("t3_ovf_set", 32'(ovf), 1);
        chk("t3_count_drop", 32'(count), 16);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("t3_ovf_clr", 32'(ovf), 0);
        push(8'hFE, 1'b0);
        ovf_clr = 1'b1;
        wr_off();
        chk("t3_set_wins", 32'(ovf), 1);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("t3_ovf_clr2", 32'(ovf), 0);
        tx_hold = 1'b0;
        wait_done();
        @(negedge clk);
        push(8'hEE, 1'b1);
        wr_off();
        chk("t3_fullpop_count", 32'(count), 16);
        chk("t3_fullpop_full", 32'(full), 1);
        chk("t3_fullpop_ovf", 32'(ovf), 0);
        drain(1200);
        chk("t3_empty", 32'(empty), 1);

        // Wrap-around: 40 bytes in bursts of 10
        mark = dv_total;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 10; i++) push(8'(b * 10 + i), 1'b1);
            wr_off();
            drain(800);
        end
        chk("t4_dv_count", dv_total - mark, 40);
        chk("t4_ovf", 32'(ovf), 0);

        // Transmitter held active blocks launch
        tx_force = 1'b1;
        mark = dv_total;
        for (int i = 0; i < 3; i++) push(8'hC0 + 8'(i), 1'b1);
        wr_off();
        repeat (8) @(negedge clk);
        chk("t5_no_dv", dv_total - mark, 0);
        chk("t5_count", 32'(count), 3);
        rel_cyc = cyc;
        tx_force = 1'b0;
        for (int i = 0; i < 20 && dv_total == mark; i++) @(negedge clk);
        chk("t5_release_lat", dv_cyc - rel_cyc, 2);
        drain(400);
        chk("t5_dv_count", dv_total - mark, 3);

        // Reset while in WAIT_DONE with 5 queued
        tx_hold = 1'b1;
        for (int i = 0; i < 6; i++) push(8'h60 + 8'(i), 1'b1);
        wr_off();
        @(negedge clk);
        chk("t6_count_pre", 32'(count), 5);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_dv", 32'(tx_dv), 0);
        chk("t6_count", 32'(count), 0);
        chk("t6_empty", 32'(empty), 1);
        chk("t6_busy", 32'(busy), 0);
        sb.delete();
        mark = dv_total;
        tx_hold = 1'b0;
        wait_done();
        repeat (5) @(negedge clk);
        chk("t6_stray_done", dv_total - mark, 0);
        chk("t6_empty_after", 32'(empty), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
